// File: rtl/quad_encoder_reader_if.sv
// Encoder-side signal bundle for quad_encoder_reader.
// The master drives the raw quadrature channels; the slave (the reader)
// returns position, speed and status.
interface quad_encoder_reader_if #(
   parameter int POS_WIDTH = 16,
   parameter int SPD_WIDTH = 16
);
   logic                 enc_a;
   logic                 enc_b;
   logic [POS_WIDTH-1:0] position;
   logic [SPD_WIDTH-1:0] speed;
   logic                 speed_valid;
   logic                 dir;
   logic                 err;

   modport master (
      output enc_a, enc_b,
      input  position, speed, speed_valid, dir, err
   );

   modport slave (
      input  enc_a, enc_b,
      output position, speed, speed_valid, dir, err
   );
endinterface

// File: rtl/quad_encoder_reader.sv
// Quadrature encoder reader: synchronizes and de-glitches channels A/B,
// decodes x4 steps into a wrapping signed position, tracks direction,
// flags illegal double-bit transitions and measures net steps per gate window.
module quad_encoder_reader #(
   parameter int POS_WIDTH   = 16,
   parameter int SPD_WIDTH   = 16,
   parameter int GATE_CYCLES = 12000,
   parameter int FILTER      = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   quad_encoder_reader_if.slave  bus
);

   localparam int CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int FLT_W = $clog2(FILTER + 1);
   // Accumulator holds +/-GATE_CYCLES with headroom for the closing step.
   localparam int ACC_W = $clog2(GATE_CYCLES + 1) + 2;
   localparam int SUM_W = ((ACC_W > SPD_WIDTH) ? ACC_W : SPD_WIDTH) + 1;

   // Channel pairs are packed as {A,B} throughout.
   logic [1:0]              sync_meta;
   logic [1:0]              sync_ab;
   logic [1:0]              filt_ab;
   logic [1:0]              prev_ab;
   logic [FLT_W-1:0]        flt_cnt [2];

   logic signed [1:0]       step_d;
   logic signed [1:0]       step_r;
   logic                    illegal_d;

   logic [POS_WIDTH-1:0]    pos_q;
   logic                    dir_q;
   logic                    err_q;

   logic [CNT_W-1:0]        gate_cnt;
   logic                    gate_end;
   logic signed [ACC_W-1:0] acc;
   logic signed [SUM_W-1:0] win_sum;
   logic [SUM_W-1:0]        win_mag;
   logic [SPD_WIDTH-1:0]    speed_sat;
   logic [SPD_WIDTH-1:0]    speed_q;
   logic                    speed_valid_q;

   // Two-flop synchronizer on the asynchronous encoder channels.
   // NOTE: no reset here on purpose -- the chain keeps sampling through rst so
   // the filter can load a settled encoder value on the reset edge.
   always_ff @(posedge clk) begin
      sync_meta <= {bus.enc_a, bus.enc_b};
      sync_ab   <= sync_meta;
   end

   // Per-channel glitch filter: accept a change once it has persisted FILTER cycles.
   // NOTE: sequential state uses non-blocking assignments so every flop sees
   // the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_ab <= sync_ab;
         for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync_ab[i] == filt_ab[i]) begin
               flt_cnt[i] <= '0;
            end else if (flt_cnt[i] == FLT_W'(FILTER - 1)) begin
               filt_ab[i] <= sync_ab[i];
               flt_cnt[i] <= '0;
            end else begin
               flt_cnt[i] <= flt_cnt[i] + FLT_W'(1);
            end
         end
      end
   end

   // x4 transition decode of previous vs current filtered state.
   // NOTE: outputs get defaults first so no path leaves them unassigned (no latch).
   always_comb begin
      step_d    = 2'sd0;
      illegal_d = 1'b0;
      case ({prev_ab, filt_ab})
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_d = 2'sd1;
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_d = -2'sd1;
         4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: illegal_d = 1'b1;
         default: ;
      endcase
   end

   // Registered decoder stage: latch the step and the sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_ab <= sync_ab;
         step_r  <= 2'sd0;
         err_q   <= 1'b0;
      end else begin
         prev_ab <= filt_ab;
         step_r  <= step_d;
         if (illegal_d) err_q <= 1'b1;
      end
   end

   // Position accumulates steps with natural two's-complement wrap; dir follows the last step.
   always_ff @(posedge clk) begin
      if (rst) begin
         pos_q <= '0;
         dir_q <= 1'b0;
      end else begin
         pos_q <= pos_q + POS_WIDTH'(step_r);
         if (step_r == 2'sd1)       dir_q <= 1'b1;
         else if (step_r == -2'sd1) dir_q <= 1'b0;
      end
   end

   // Closing-window magnitude includes the step landing on the last gate cycle.
   always_comb begin
      gate_end  = (gate_cnt == CNT_W'(GATE_CYCLES - 1));
      win_sum   = SUM_W'(acc) + SUM_W'(step_r);
      win_mag   = win_sum[SUM_W-1] ? -win_sum : win_sum;
      speed_sat = (win_mag > SUM_W'({SPD_WIDTH{1'b1}})) ? '1 : win_mag[SPD_WIDTH-1:0];
   end

   // Gate counter, net-step accumulator and speed publication.
   always_ff @(posedge clk) begin
      if (rst) begin
         gate_cnt      <= '0;
         acc           <= '0;
         speed_q       <= '0;
         speed_valid_q <= 1'b0;
      end else begin
         speed_valid_q <= gate_end;
         if (gate_end) begin
            gate_cnt <= '0;
            acc      <= '0;
            speed_q  <= speed_sat;
         end else begin
            gate_cnt <= gate_cnt + CNT_W'(1);
            acc      <= acc + ACC_W'(step_r);
         end
      end
   end

   assign bus.position    = pos_q;
   assign bus.speed       = speed_q;
   assign bus.speed_valid = speed_valid_q;
   assign bus.dir         = dir_q;
   assign bus.err         = err_q;

endmodule
